// File: rtl/dmac_read_initiator_if.sv
// Bundles the request, AXI4 AR/R and internal data/error signals of the DMA read initiator.
// "master" is the initiator's view; "slave" is the view of whatever surrounds it.
interface dmac_read_initiator_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32
);
  logic               rd_req_valid;
  logic               rd_req_ready;
  logic [ADDR_WD-1:0] rd_req_addr;
  logic [1:0]         rd_req_burst;
  logic [7:0]         rd_req_len;
  logic [2:0]         rd_req_size;
  logic               rd_req_last;

  logic               m_axi_arvalid;
  logic               m_axi_arready;
  logic [ADDR_WD-1:0] m_axi_araddr;
  logic [7:0]         m_axi_arlen;
  logic [2:0]         m_axi_arsize;
  logic [1:0]         m_axi_arburst;

  logic               m_axi_rvalid;
  logic               m_axi_rready;
  logic [DATA_WD-1:0] m_axi_rdata;
  logic [1:0]         m_axi_rresp;
  logic               m_axi_rlast;

  logic               data_out_valid;
  logic               data_out_ready;
  logic [DATA_WD-1:0] data_out;
  logic               data_out_last;

  logic               err_valid;
  logic [1:0]         err_resp;
  logic               err_rlast;
  logic               busy;

  modport master (
    input  rd_req_valid, rd_req_addr, rd_req_burst, rd_req_len, rd_req_size, rd_req_last,
    output rd_req_ready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    output m_axi_rready,
    output data_out_valid, data_out, data_out_last,
    input  data_out_ready,
    output err_valid, err_resp, err_rlast, busy
  );

  modport slave (
    output rd_req_valid, rd_req_addr, rd_req_burst, rd_req_len, rd_req_size, rd_req_last,
    input  rd_req_ready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    input  m_axi_rready,
    input  data_out_valid, data_out, data_out_last,
    output data_out_ready,
    input  err_valid, err_resp, err_rlast, busy
  );
endinterface

// File: rtl/dmac_read_initiator.sv
// AXI4 read-side master of the DMA controller: issues AR bursts, tracks them in order
// and forwards R beats to the internal stream, flagging response and rlast errors.
module dmac_read_initiator #(
  parameter int ADDR_WD         = 32,
  parameter int DATA_WD         = 32,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dmac_read_initiator_if.master bus
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic               arvalid_q;
  logic [ADDR_WD-1:0] araddr_q;
  logic [7:0]         arlen_q;
  logic [2:0]         arsize_q;
  logic [1:0]         arburst_q;

  logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]         fifo_len_q  [MAX_OUTSTANDING];
  logic               fifo_last_q [MAX_OUTSTANDING];
  logic [7:0]         beat_cnt_q, beat_cnt_d;

  logic               err_valid_q, err_valid_d;
  logic [1:0]         err_resp_q, err_resp_d;
  logic               err_rlast_q, err_rlast_d;

  logic               fifo_nonempty;
  logic [7:0]         head_len;
  logic               head_last;
  logic               final_beat;
  logic               req_ready;
  logic               req_hs;
  logic               r_ready;
  logic               r_hs;
  logic               burst_done;

  // The tracking FIFO holds exactly the outstanding bursts, so its occupancy is cnt_out.
  assign fifo_nonempty = (cnt_out_q != '0);
  assign head_len      = fifo_len_q[rd_ptr_q];
  assign head_last     = fifo_last_q[rd_ptr_q];
  assign final_beat    = (beat_cnt_q == head_len);

  assign req_ready  = !rst && (!arvalid_q || bus.m_axi_arready) && (cnt_out_q < CNT_MAX);
  assign req_hs     = bus.rd_req_valid && req_ready;
  assign r_ready    = !rst && bus.data_out_ready && fifo_nonempty;
  assign r_hs       = bus.m_axi_rvalid && r_ready;
  assign burst_done = r_hs && final_beat;

  always_comb begin
    cnt_out_d = cnt_out_q;
    if (req_hs && !burst_done) begin
      cnt_out_d = cnt_out_q + CNT_W'(1);
    end else if (!req_hs && burst_done) begin
      cnt_out_d = cnt_out_q - CNT_W'(1);
    end

    beat_cnt_d = beat_cnt_q;
    if (r_hs) begin
      beat_cnt_d = final_beat ? 8'd0 : beat_cnt_q + 8'd1;
    end

    // Termination follows the beat count; rlast is only cross-checked.
    err_resp_d  = r_hs ? bus.m_axi_rresp : 2'b00;
    err_rlast_d = r_hs && (bus.m_axi_rlast != final_beat);
    err_valid_d = (err_resp_d != 2'b00) || err_rlast_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      cnt_out_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      err_valid_q <= 1'b0;
      err_resp_q  <= 2'b00;
      err_rlast_q <= 1'b0;
    end else begin
      if (req_hs) begin
        arvalid_q             <= 1'b1;
        araddr_q              <= bus.rd_req_addr;
        arlen_q               <= bus.rd_req_len;
        arsize_q              <= bus.rd_req_size;
        arburst_q             <= bus.rd_req_burst;
        fifo_len_q[wr_ptr_q]  <= bus.rd_req_len;
        fifo_last_q[wr_ptr_q] <= bus.rd_req_last;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end else if (bus.m_axi_arready) begin
        arvalid_q <= 1'b0;
      end

      if (burst_done) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      cnt_out_q   <= cnt_out_d;
      beat_cnt_q  <= beat_cnt_d;
      err_valid_q <= err_valid_d;
      err_resp_q  <= err_resp_d;
      err_rlast_q <= err_rlast_d;
    end
  end

  assign bus.rd_req_ready   = req_ready;
  assign bus.m_axi_arvalid  = arvalid_q;
  assign bus.m_axi_araddr   = araddr_q;
  assign bus.m_axi_arlen    = arlen_q;
  assign bus.m_axi_arsize   = arsize_q;
  assign bus.m_axi_arburst  = arburst_q;
  assign bus.m_axi_rready   = r_ready;
  assign bus.data_out_valid = !rst && bus.m_axi_rvalid && fifo_nonempty;
  assign bus.data_out       = bus.m_axi_rdata;
  assign bus.data_out_last  = !rst && fifo_nonempty && final_beat && head_last;
  assign bus.err_valid      = err_valid_q;
  assign bus.err_resp       = err_resp_q;
  assign bus.err_rlast      = err_rlast_q;
  assign bus.busy           = fifo_nonempty;

  // Request generator never exceeds the configured burst length.
  a_len_in_range : assert property (@(posedge clk) disable iff (rst)
    req_hs |-> (bus.rd_req_len < 8'(MAX_BURST_LEN)));
endmodule

// File: tb/tb_dmac_read_initiator.sv
// Scoreboard bench for dmac_read_initiator: a request-level model predicts AR, data and error outputs.
module tb_dmac_read_initiator;
  localparam int BIG = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmac_read_initiator_if #(.ADDR_WD(32), .DATA_WD(32)) bus ();

  dmac_read_initiator #(
    .ADDR_WD(32), .DATA_WD(32), .MAX_BURST_LEN(16), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] data_fn(input logic [31:0] a, input int b);
    return a ^ (32'h9E37_0000 + 32'(b) * 32'h0001_0011);
  endfunction

  // Stimulus knobs for the AXI slave / sink model.
  bit ar_rand = 0, d_rand = 0, r_gap = 0, err_rand = 0, r_en = 1;
  logic d_force = 1'b1;
  int r_budget = BIG;
  int inj_resp_beat = -1, inj_rlast_beat = -1;
  logic [1:0] inj_resp = 2'b00;

  // ---------------- AXI read slave model ----------------
  logic [31:0] dq_addr[$];
  int dq_len[$];
  bit r_active = 0;
  logic [31:0] r_addr;
  int r_len, r_beat;
  bit d_rst, d_hs_r;

  initial begin
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata = '0;
    bus.m_axi_rresp = 2'b00;
    bus.m_axi_rlast = 1'b0;
    bus.data_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      d_rst = rst;
      d_hs_r = 0;
      if (rst) begin
        dq_addr.delete();
        dq_len.delete();
      end else begin
        d_hs_r = bus.m_axi_rvalid && bus.m_axi_rready;
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          dq_addr.push_back(bus.m_axi_araddr);
          dq_len.push_back(int'(bus.m_axi_arlen));
        end
      end
      @(posedge clk);
      #2;
      bus.m_axi_arready = ar_rand ? 1'($urandom % 2) : 1'b1;
      bus.data_out_ready = d_rand ? 1'($urandom % 2) : d_force;
      if (d_rst) begin
        r_active = 0;
        bus.m_axi_rvalid = 1'b0;
      end else if (!(bus.m_axi_rvalid && !d_hs_r)) begin
        bus.m_axi_rvalid = 1'b0;
        if (d_hs_r) begin
          if (r_beat == r_len) r_active = 0;
          else r_beat++;
          if (r_budget > 0) r_budget--;
        end
        if (!r_active && dq_addr.size() > 0) begin
          r_addr = dq_addr.pop_front();
          r_len = dq_len.pop_front();
          r_beat = 0;
          r_active = 1;
        end
        if (r_active && r_en && r_budget > 0 && (!r_gap || ($urandom % 4) != 0)) begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rdata = data_fn(r_addr, r_beat);
          bus.m_axi_rresp = (r_beat == inj_resp_beat) ? inj_resp : 2'b00;
          bus.m_axi_rlast = (r_beat == r_len) ^ (r_beat == inj_rlast_beat);
          if (err_rand) begin
            if (($urandom % 8) == 0) bus.m_axi_rresp = 2'($urandom_range(1, 3));
            if (($urandom % 10) == 0) bus.m_axi_rlast = ~bus.m_axi_rlast;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] sb_addr[$];
  int sb_len[$];
  bit sb_last[$];
  logic [31:0] ae_addr[$];
  int ae_len[$], ae_size[$], ae_burst[$];
  int m_beat = 0;
  bit pe_v = 0, pe_rl = 0;
  logic [1:0] pe_resp = 2'b00;
  int n_beats = 0, n_err = 0, n_last = 0;
  logic [1:0] last_err_resp = 2'b00;
  bit last_err_rlast = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb_addr.delete(); sb_len.delete(); sb_last.delete();
      ae_addr.delete(); ae_len.delete(); ae_size.delete(); ae_burst.delete();
      m_beat = 0;
      pe_v = 0; pe_rl = 0; pe_resp = 2'b00;
    end else begin
      chk("err_valid", 64'(bus.err_valid), 64'(pe_v));
      if (pe_v) begin
        chk("err_resp", 64'(bus.err_resp), 64'(pe_resp));
        chk("err_rlast", 64'(bus.err_rlast), 64'(pe_rl));
      end
      if (bus.err_valid) begin
        n_err++;
        last_err_resp = bus.err_resp;
        last_err_rlast = bus.err_rlast;
      end
      chk("rd_req_ready", 64'(bus.rd_req_ready),
          64'((ae_addr.size() == 0 || bus.m_axi_arready) && sb_len.size() < 4));
      chk("arvalid", 64'(bus.m_axi_arvalid), 64'(ae_addr.size() != 0));
      chk("busy", 64'(bus.busy), 64'(sb_len.size() != 0));
      chk("rready", 64'(bus.m_axi_rready), 64'(bus.data_out_ready && sb_len.size() != 0));
      chk("data_out_valid", 64'(bus.data_out_valid), 64'(bus.m_axi_rvalid && sb_len.size() != 0));

      if (bus.m_axi_arvalid && bus.m_axi_arready && ae_addr.size() > 0) begin
        chk("araddr", 64'(bus.m_axi_araddr), 64'(ae_addr.pop_front()));
        chk("arlen", 64'(bus.m_axi_arlen), 64'(ae_len.pop_front()));
        chk("arsize", 64'(bus.m_axi_arsize), 64'(ae_size.pop_front()));
        chk("arburst", 64'(bus.m_axi_arburst), 64'(ae_burst.pop_front()));
      end

      pe_v = 0; pe_rl = 0; pe_resp = 2'b00;
      if (bus.data_out_valid && bus.data_out_ready) begin
        if (sb_len.size() == 0) begin
          timeout("unexpected_beat");
        end else begin
          chk("data_out", 64'(bus.data_out), 64'(data_fn(sb_addr[0], m_beat)));
          chk("data_out_last", 64'(bus.data_out_last), 64'(sb_last[0] && m_beat == sb_len[0]));
          n_beats++;
          if (bus.data_out_last) n_last++;
          pe_resp = bus.m_axi_rresp;
          pe_rl = (bus.m_axi_rlast != (m_beat == sb_len[0]));
          pe_v = (pe_resp != 2'b00) || pe_rl;
          if (m_beat == sb_len[0]) begin
            void'(sb_addr.pop_front());
            void'(sb_len.pop_front());
            void'(sb_last.pop_front());
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end
      end

      if (bus.rd_req_valid && bus.rd_req_ready) begin
        sb_addr.push_back(bus.rd_req_addr);
        sb_len.push_back(int'(bus.rd_req_len));
        sb_last.push_back(bus.rd_req_last);
        ae_addr.push_back(bus.rd_req_addr);
        ae_len.push_back(int'(bus.rd_req_len));
        ae_size.push_back(int'(bus.rd_req_size));
        ae_burst.push_back(int'(bus.rd_req_burst));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_req(input logic [31:0] addr, input int len, input int size,
                          input int burst, input bit last);
    bit ok = 0;
    @(posedge clk); #1;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr = addr;
    bus.rd_req_len = 8'(len);
    bus.rd_req_size = 3'(size);
    bus.rd_req_burst = 2'(burst);
    bus.rd_req_last = last;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (bus.rd_req_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) timeout("send_req");
    else begin @(posedge clk); #1; end
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk); #1;
      if (sb_len.size() == 0 && ae_addr.size() == 0) ok = 1;
    end
    if (!ok) timeout("wait_idle");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 64'(bus.m_axi_arvalid), 64'(0));
    chk({tag, "_araddr"}, 64'(bus.m_axi_araddr), 64'(0));
    chk({tag, "_arlen"}, 64'(bus.m_axi_arlen), 64'(0));
    chk({tag, "_rready"}, 64'(bus.m_axi_rready), 64'(0));
    chk({tag, "_dvalid"}, 64'(bus.data_out_valid), 64'(0));
    chk({tag, "_dlast"}, 64'(bus.data_out_last), 64'(0));
    chk({tag, "_err_valid"}, 64'(bus.err_valid), 64'(0));
    chk({tag, "_err_resp"}, 64'(bus.err_resp), 64'(0));
    chk({tag, "_err_rlast"}, 64'(bus.err_rlast), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_req_ready"}, 64'(bus.rd_req_ready), 64'(0));
  endtask

  int b0, e0, l0, acc;
  bit found;

  initial begin
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr = '0;
    bus.rd_req_len = '0;
    bus.rd_req_size = '0;
    bus.rd_req_burst = '0;
    bus.rd_req_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.rd_req_ready), 64'(1));

    // Single burst, everything ready.
    b0 = n_beats; e0 = n_err; l0 = n_last;
    send_req(32'h1000, 3, 2, 1, 1);
    wait_idle(200);
    @(negedge clk);
    chk("single_beats", 64'(n_beats - b0), 64'(4));
    chk("single_lasts", 64'(n_last - l0), 64'(1));
    chk("single_errs", 64'(n_err - e0), 64'(0));
    chk("single_busy", 64'(bus.busy), 64'(0));

    // Back-to-back requests with R withheld.
    @(posedge clk); #1;
    r_en = 0;
    acc = 0;
    bus.rd_req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.rd_req_addr = 32'h2000 + 32'(acc) * 32'h40;
      bus.rd_req_len = 8'd0;
      bus.rd_req_size = 3'd2;
      bus.rd_req_burst = 2'd1;
      bus.rd_req_last = 1'b0;
      @(negedge clk);
      chk("b2b_ready", 64'(bus.rd_req_ready), 64'(c < 4));
      if (bus.rd_req_ready) acc++;
      @(posedge clk); #1;
    end
    bus.rd_req_valid = 1'b0;
    chk("b2b_accepted", 64'(acc), 64'(4));
    r_budget = 1;
    r_en = 1;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        found = 1;
        chk("full_ready_low", 64'(bus.rd_req_ready), 64'(0));
        @(negedge clk);
        chk("reopen_ready", 64'(bus.rd_req_ready), 64'(1));
      end
    end
    if (!found) timeout("b2b_first_beat");
    @(posedge clk); #1;
    r_budget = BIG;
    wait_idle(200);

    // Random sink backpressure over three full-length bursts.
    d_rand = 1;
    b0 = n_beats;
    send_req(32'h3000, 15, 2, 1, 0);
    send_req(32'h3100, 15, 2, 1, 0);
    send_req(32'h3200, 15, 2, 1, 1);
    wait_idle(2000);
    chk("bp_beats", 64'(n_beats - b0), 64'(48));
    d_rand = 0;

    // SLVERR on beat 2.
    e0 = n_err; b0 = n_beats;
    inj_resp_beat = 1; inj_resp = 2'b10;
    send_req(32'h4000, 3, 2, 1, 1);
    wait_idle(200);
    @(negedge clk);
    chk("resp_err_count", 64'(n_err - e0), 64'(1));
    chk("resp_err_value", 64'(last_err_resp), 64'(2'b10));
    chk("resp_err_beats", 64'(n_beats - b0), 64'(4));
    @(posedge clk); #1;
    inj_resp_beat = -1;

    // Early rlast on beat 2.
    e0 = n_err; b0 = n_beats;
    inj_rlast_beat = 1;
    send_req(32'h4800, 3, 2, 1, 0);
    wait_idle(200);
    @(negedge clk);
    chk("rlast_err_count", 64'(n_err - e0), 64'(1));
    chk("rlast_err_flag", 64'(last_err_rlast), 64'(1));
    chk("rlast_beats", 64'(n_beats - b0), 64'(4));
    @(posedge clk); #1;
    inj_rlast_beat = -1;

    // Reset in the middle of a burst.
    b0 = n_beats;
    r_budget = 2;
    send_req(32'h5000, 3, 2, 1, 1);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      if (n_beats - b0 >= 2) found = 1;
    end
    if (!found) timeout("mid_burst_beats");
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    r_budget = BIG;
    b0 = n_beats; e0 = n_err;
    send_req(32'h6000, 3, 2, 1, 1);
    wait_idle(200);
    chk("post_reset_beats", 64'(n_beats - b0), 64'(4));
    chk("post_reset_errs", 64'(n_err - e0), 64'(0));

    // Fully randomised traffic with error injection.
    ar_rand = 1; d_rand = 1; r_gap = 1; err_rand = 1;
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_req({$urandom} & 32'hFFFF_FFFC, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 1'($urandom % 2));
    end
    wait_idle(5000);
    ar_rand = 0; d_rand = 0; r_gap = 0; err_rand = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_sb_empty", 64'(sb_len.size()), 64'(0));
    chk("final_busy", 64'(bus.busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmac_read_initiator.md
# dmac_read_initiator

AXI4 read-side master engine of the DMA controller, the counterpart of the write initiator on the read path. It accepts per-burst read requests from the read request generator, issues them on the AR channel, and tracks up to MAX_OUTSTANDING bursts in order. It forwards R-channel beats to the internal data stream, marking transfer ends, and reports protocol and response errors.

## Interface
- ADDR_WD, 32, address width
- DATA_WD, 32, data width
- MAX_BURST_LEN, 16, max beats per burst (requests never exceed it)
- MAX_OUTSTANDING, 4, max bursts accepted but not fully received (power of 2, ≥2)

- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- rd_req_valid  in  1  request valid
- rd_req_ready  out  1  request accepted when valid&&ready
- rd_req_addr  in  ADDR_WD  burst start address
- rd_req_burst  in  2  AXI burst type
- rd_req_len  in  8  AXI len (beats−1)
- rd_req_size  in  3  AXI size
- rd_req_last  in  1  final burst of the DMA transfer
- m_axi_arvalid/araddr/arlen/arsize/arburst  out  1/ADDR_WD/8/3/2  AR channel
- m_axi_arready  in  1
- m_axi_rvalid  in  1;  m_axi_rdata  in  DATA_WD;  m_axi_rresp  in  2;  m_axi_rlast  in  1
- m_axi_rready  out  1
- data_out_valid  out  1;  data_out_ready  in  1
- data_out  out  DATA_WD  beat payload (= m_axi_rdata)
- data_out_last  out  1  last beat of a burst flagged rd_req_last
- err_valid  out  1  one-cycle error pulse
- err_resp  out  2  rresp of the offending beat (00 for a pure rlast error)
- err_rlast  out  1  rlast mismatch flag
- busy  out  1  any burst outstanding

## Operation
- AR stage: one register slot (araddr/arlen/arsize/arburst + arvalid). Loaded on request handshake. arvalid held with stable payload until arready.
- rd_req_ready = !rst && (!m_axi_arvalid || m_axi_arready) && cnt_out < MAX_OUTSTANDING.
- cnt_out: bursts accepted and not yet fully received, width clog2(MAX_OUTSTANDING)+1. +1 on request handshake, −1 on final beat handshake. Both in one cycle: unchanged. No same-cycle bypass of a freed slot.
- Tracking FIFO, depth MAX_OUTSTANDING, entries {len, last}. Push on request handshake. Head describes the burst currently receiving. Pop on final beat.
- beat_cnt (8 bit): beats of the head burst. Reset to 0 on pop, otherwise +1 per R handshake. Final beat: beat_cnt == head.len.
- R path is combinational pass-through:
  - m_axi_rready = data_out_ready && fifo_nonempty
  - data_out_valid = m_axi_rvalid && fifo_nonempty
  - data_out = m_axi_rdata
  - data_out_last = final beat && head.last
- Burst termination is governed by beat_cnt, never by m_axi_rlast.
- Errors, registered and pulsed the cycle after the R handshake:
  - rresp != 00: err_resp = rresp.
  - m_axi_rlast != final beat: err_rlast = 1.
  - Both can occur on the same beat. The beat is still forwarded either way.
- busy = (cnt_out != 0).
- R data arriving with the FIFO empty is not accepted (rready low).

## Timing
- Reset values, held while rst is high: arvalid 0, AR payload 0, rready 0, data_out_valid 0, data_out_last 0, err_* 0, busy 0, rd_req_ready 0, cnt_out 0, beat_cnt 0, FIFO empty.
- rd_req_ready rises the first cycle after rst deasserts.
- rst asserted mid-operation: the next edge clears all state. Partially received bursts are dropped with no error report.
- Request handshake at edge N: arvalid high from N+1. With arready tied high, one request is accepted per cycle until cnt_out reaches MAX_OUTSTANDING.
- R to data_out latency is 0 cycles. err_valid latency is 1 cycle.
- data_out_ready low stalls R with no beat loss and no beat duplication.

## Test plan
- Single burst, addr 0x1000, len 3, size 2, last 1, arready/rvalid/data_out_ready high → one AR (araddr 0x1000, arlen 3). 4 beats forwarded; data_out_last only on beat 4. busy falls after beat 4. err_valid never asserts.
- 6 back-to-back requests (len 0), arready high, R withheld → requests 1–4 accepted in consecutive cycles; rd_req_ready stays low after the 4th. Returning one beat reopens ready the following cycle.
- Random data_out_ready backpressure (~50%) over 3 bursts of len 15 → 48 beats delivered in order, each exactly once. m_axi_rready tracks data_out_ready.
- Beat 2 of a len-3 burst returns rresp 10 → beat forwarded; err_valid=1, err_resp=10 the next cycle. Burst completes normally.
- rlast asserted on beat 2 of a len-3 burst → err_rlast pulse. The burst still ends after 4 beats by count.
- rst asserted after 2 of 4 beats → the following cycle shows all outputs at reset values. A new request then completes cleanly.
